// File: rtl/song_sequencer_ctrl_pkg.sv
// Shared types for the song sequencer: FSM state encoding and the ROM note word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package song_player_pkg;

  localparam int NOTE_PITCH_W   = 7;
  localparam int NOTE_DUR_W     = 14;
  // A zero duration in a ROM word marks the end of the song.
  localparam int END_MARKER_DUR = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_NOTE,
    S_GAP,
    S_PAUSED
  } seq_state_e;

  typedef struct packed {
    logic [NOTE_PITCH_W-1:0] pitch;
    logic [NOTE_DUR_W-1:0]   dur;
  } note_word_t;

endpackage

// File: rtl/song_sequencer_ctrl_if.sv
// UI, song ROM and tone-generator signals of the song sequencer.
// Latency: n/a (wires only).
// Backpressure: ROM reads wait for rom_valid; UI inputs are single-cycle pulses.
interface song_sequencer_ctrl_if #(
  parameter int SONG_W  = 3,
  parameter int IDX_W   = 8,
  parameter int PITCH_W = 7,
  parameter int DUR_W   = 14
);
  logic                      play;
  logic                      pause;
  logic                      stop;
  logic [SONG_W-1:0]         song_select;
  logic [SONG_W+IDX_W-1:0]   rom_addr;
  logic                      rom_rd;
  logic                      rom_valid;
  logic [PITCH_W+DUR_W-1:0]  rom_data;
  logic [PITCH_W-1:0]        note_pitch;
  logic                      note_on;
  logic [IDX_W-1:0]          note_index;
  logic                      busy;
  logic                      song_done;

  // Sequencer side.
  modport master (
    input  play, pause, stop, song_select, rom_valid, rom_data,
    output rom_addr, rom_rd, note_pitch, note_on, note_index, busy, song_done
  );

  // UI / ROM / tone-generator side.
  modport slave (
    output play, pause, stop, song_select, rom_valid, rom_data,
    input  rom_addr, rom_rd, note_pitch, note_on, note_index, busy, song_done
  );
endinterface

// File: rtl/song_sequencer_ctrl_timer.sv
// Note/gap timer: counts TICKS_PER_UNIT clocks per unit and dur units per load.
// Latency: expire_o is combinational in the final counted cycle.
// Backpressure: counts only while run_i is high; load_i overrides run_i.
module note_duration_timer #(
  parameter int TICKS_PER_UNIT = 100_000,
  parameter int DUR_W          = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [DUR_W-1:0] dur_i,
  input  logic             run_i,
  output logic             expire_o
);

  localparam int UNIT_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [UNIT_W-1:0] UNIT_MAX = UNIT_W'(TICKS_PER_UNIT - 1);

  logic [UNIT_W-1:0] unit_cnt_q;
  logic [DUR_W-1:0]  dur_left_q;
  logic              unit_wrap;

  assign unit_wrap = (unit_cnt_q == UNIT_MAX);
  // Last clock of the last unit: the caller changes state on this cycle.
  assign expire_o  = run_i && unit_wrap && (dur_left_q == DUR_W'(1));

  // Unit prescaler and remaining-unit counter; both freeze when run_i is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      unit_cnt_q <= '0;
      dur_left_q <= '0;
    end else if (load_i) begin
      unit_cnt_q <= '0;
      dur_left_q <= dur_i;
    end else if (run_i && (dur_left_q != '0)) begin
      if (unit_wrap) begin
        unit_cnt_q <= '0;
        dur_left_q <= dur_left_q - DUR_W'(1);
      end else begin
        unit_cnt_q <= unit_cnt_q + UNIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/song_sequencer_ctrl.sv
// Song sequencer: fetches {pitch,dur} words from the song ROM and times note/gap playback.
// Latency: play -> rom_rd 2 cycles; rom_valid -> note_on 1 cycle; note on for dur*TICKS_PER_UNIT.
// Backpressure: waits in WAIT_ROM for rom_valid; pause freezes timing. SONG_SEQ_LOOP_EN loops the song.
module song_sequencer_ctrl
  import song_player_pkg::*;
#(
  parameter int CLOCK_FREQ     = 100_000_000,
  parameter int TICKS_PER_UNIT = 100_000,
  parameter int SONG_W         = 3,
  parameter int IDX_W          = 8,
  parameter int PITCH_W        = NOTE_PITCH_W,
  parameter int DUR_W          = NOTE_DUR_W,
  parameter int GAP_UNITS      = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  song_sequencer_ctrl_if.master io
);

`ifdef SONG_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [DUR_W-1:0] GAP_DUR = DUR_W'(GAP_UNITS);

  // A unit cannot be shorter than one clock or longer than one second of clocks.
  if (TICKS_PER_UNIT < 1 || TICKS_PER_UNIT > CLOCK_FREQ) begin : g_bad_ticks
    $error("TICKS_PER_UNIT out of range for CLOCK_FREQ");
  end

  seq_state_e                state_q;
  seq_state_e                ret_q;
  logic [SONG_W-1:0]         song_q;
  logic [IDX_W-1:0]          note_idx_q;
  logic [SONG_W+IDX_W-1:0]   rom_addr_q;
  logic                      rom_rd_q;
  logic [PITCH_W-1:0]        pitch_q;
  logic                      note_on_q;
  logic                      song_done_q;
  logic                      pause_pend_q;

  logic [PITCH_W-1:0]        rom_pitch;
  logic [DUR_W-1:0]          rom_dur;
  logic                      end_marker;
  logic                      pause_eff;
  logic                      tmr_load;
  logic [DUR_W-1:0]          tmr_dur;
  logic                      tmr_run;
  logic                      tmr_expire;

  assign rom_pitch  = io.rom_data[PITCH_W+DUR_W-1:DUR_W];
  assign rom_dur    = io.rom_data[DUR_W-1:0];
  assign end_marker = (rom_dur == DUR_W'(END_MARKER_DUR));
  // play outranks a same-cycle pause; a pause held back from FETCH/WAIT_ROM is still owed.
  assign pause_eff  = (io.pause && !io.play) || pause_pend_q;
  assign tmr_run    = (state_q == S_NOTE) || (state_q == S_GAP);

  // Timer reload: note length on a valid ROM word, gap length as the note expires.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dur  = rom_dur;
    if (!io.stop) begin
      if (state_q == S_WAIT_ROM && io.rom_valid && !end_marker) begin
        tmr_load = 1'b1;
      end else if (state_q == S_NOTE && tmr_expire) begin
        tmr_load = 1'b1;
        tmr_dur  = GAP_DUR;
      end
    end
  end

  note_duration_timer #(
    .TICKS_PER_UNIT (TICKS_PER_UNIT),
    .DUR_W          (DUR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (tmr_load),
    .dur_i    (tmr_dur),
    .run_i    (tmr_run),
    .expire_o (tmr_expire)
  );

  // Playback FSM with registered ROM strobe, pitch, note enable and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ret_q        <= S_IDLE;
      song_q       <= '0;
      note_idx_q   <= '0;
      rom_addr_q   <= '0;
      rom_rd_q     <= 1'b0;
      pitch_q      <= '0;
      note_on_q    <= 1'b0;
      song_done_q  <= 1'b0;
      pause_pend_q <= 1'b0;
    end else begin
      rom_rd_q    <= 1'b0;
      song_done_q <= 1'b0;
      if (io.stop) begin
        state_q      <= S_IDLE;
        note_on_q    <= 1'b0;
        note_idx_q   <= '0;
        pause_pend_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (io.play) begin
              song_q       <= io.song_select;
              note_idx_q   <= '0;
              pause_pend_q <= 1'b0;
              state_q      <= S_FETCH;
            end
          end
          S_FETCH: begin
            rom_rd_q   <= 1'b1;
            rom_addr_q <= {song_q, note_idx_q};
            if (io.pause && !io.play) pause_pend_q <= 1'b1;
            state_q    <= S_WAIT_ROM;
          end
          S_WAIT_ROM: begin
            if (io.pause && !io.play) pause_pend_q <= 1'b1;
            if (io.rom_valid) begin
              if (end_marker) begin
                song_done_q <= 1'b1;
                note_idx_q  <= '0;
                note_on_q   <= 1'b0;
                state_q     <= LOOP_EN ? S_FETCH : S_IDLE;
              end else begin
                pitch_q   <= rom_pitch;
                note_on_q <= 1'b1;
                state_q   <= S_NOTE;
              end
            end
          end
          S_NOTE: begin
            if (tmr_expire) begin
              note_on_q <= 1'b0;
              state_q   <= S_GAP;
              if (pause_eff) pause_pend_q <= 1'b1;
            end else if (pause_eff) begin
              note_on_q    <= 1'b0;
              ret_q        <= S_NOTE;
              pause_pend_q <= 1'b0;
              state_q      <= S_PAUSED;
            end
          end
          S_GAP: begin
            if (tmr_expire) begin
              if (pause_eff) pause_pend_q <= 1'b1;
              if (&note_idx_q) begin
                // Index space exhausted: treat exactly like the end marker.
                song_done_q <= 1'b1;
                note_idx_q  <= '0;
                state_q     <= LOOP_EN ? S_FETCH : S_IDLE;
              end else begin
                note_idx_q <= note_idx_q + IDX_W'(1);
                state_q    <= S_FETCH;
              end
            end else if (pause_eff) begin
              ret_q        <= S_GAP;
              pause_pend_q <= 1'b0;
              state_q      <= S_PAUSED;
            end
          end
          S_PAUSED: begin
            if (io.play) begin
              state_q   <= ret_q;
              note_on_q <= (ret_q == S_NOTE);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign io.rom_addr   = rom_addr_q;
  assign io.rom_rd     = rom_rd_q;
  assign io.note_pitch = pitch_q;
  assign io.note_on    = note_on_q;
  assign io.note_index = note_idx_q;
  assign io.busy       = (state_q != S_IDLE);
  assign io.song_done  = song_done_q;

endmodule

// File: tb/tb_song_sequencer_ctrl.sv
// Directed bench for song_sequencer_ctrl with a behavioural song ROM of programmable latency.
// Runs with TICKS_PER_UNIT=4, GAP_UNITS=1; loop scenario only when SONG_SEQ_LOOP_EN is defined.
// Inputs are driven 1 time unit after posedge; outputs are sampled there too.
module tb_song_sequencer_ctrl;
  import song_player_pkg::*;

  localparam int TPU  = 4;
  localparam int GAPU = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  song_sequencer_ctrl_if #(.SONG_W(3), .IDX_W(8), .PITCH_W(7), .DUR_W(14)) bus ();

  song_sequencer_ctrl #(
    .CLOCK_FREQ(100_000_000), .TICKS_PER_UNIT(TPU), .SONG_W(3), .IDX_W(8),
    .PITCH_W(7), .DUR_W(14), .GAP_UNITS(GAPU)
  ) dut (
    .clk(clk), .reset(reset), .io(bus)
  );

  note_word_t rom_mem [0:2047];
  int n_assert = 0;
  int n_fail   = 0;

  // ROM model: answers rom_valid rom_lat cycles after the rom_rd cycle.
  int rom_lat = 1;
  int rom_cnt = 0;
  logic [10:0] rom_addr_lat;
  always @(posedge clk) begin
    #1;
    bus.rom_valid = 1'b0;
    if (rom_cnt > 0) begin
      rom_cnt--;
      if (rom_cnt == 0) begin
        bus.rom_valid = 1'b1;
        bus.rom_data  = rom_mem[rom_addr_lat];
      end
    end
    if (bus.rom_rd === 1'b1) begin
      rom_addr_lat = bus.rom_addr;
      rom_cnt      = rom_lat;
    end
  end

  // Observers: note-on runs, silent busy runs, done pulses, ROM reads.
  int on_total, done_cnt, rd_cnt, bad_song, rd_idx0, run_len, low_len;
  logic prev_on;
  logic [2:0] exp_song;
  int q_len[$];
  int q_pitch[$];
  int q_idx[$];
  int q_low[$];
  always @(negedge clk) begin
    if (bus.note_on === 1'b1) begin
      on_total++;
      run_len++;
      if (prev_on !== 1'b1) begin
        q_idx.push_back(int'(bus.note_index));
        q_low.push_back(low_len);
        low_len = 0;
      end
    end else begin
      if (prev_on === 1'b1) begin
        q_len.push_back(run_len);
        q_pitch.push_back(int'(bus.note_pitch));
        run_len = 0;
      end
      if (bus.busy === 1'b1) low_len++;
    end
    prev_on = bus.note_on;
    if (bus.song_done === 1'b1) done_cnt++;
    if (bus.rom_rd === 1'b1) begin
      rd_cnt++;
      if (bus.rom_addr[10:8] !== exp_song) bad_song++;
      if (bus.rom_addr[7:0] == 8'd0) rd_idx0++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    on_total = 0; done_cnt = 0; rd_cnt = 0; bad_song = 0; rd_idx0 = 0;
    run_len = 0; low_len = 0;
    q_len.delete(); q_pitch.delete(); q_idx.delete(); q_low.delete();
  endtask

  task automatic pulse_play();
    bus.play = 1'b1;
    tick();
    bus.play = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();  // let the observer record the final cycle
  endtask

  task automatic wait_on(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bus.note_on === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_assert++;
    if ({bus.busy, bus.note_on, bus.rom_rd, bus.song_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/on/rd/done=%b expected 0000",
               {bus.busy, bus.note_on, bus.rom_rd, bus.song_done});
    end
    n_assert++;
    if ({bus.rom_addr, bus.note_index, bus.note_pitch} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_buses: addr=%0h idx=%0d pitch=%0d expected 0",
               bus.rom_addr, bus.note_index, bus.note_pitch);
    end
    reset = 1'b0;
    tick();
    clear_mon();
  endtask

  // Song 0 = {60,3},{62,2},end: 12 on, 7 off (4 gap + FETCH + read + valid), 8 on.
  task automatic test_basic_song();
    bit ok;
    clear_mon();
    exp_song = 3'd0; bus.song_select = 3'd0;
    bus.play = 1'b1;
    tick();
    bus.play = 1'b0;
    n_assert++;
    if (bus.rom_rd !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL play_lat1: rd=%b busy=%b expected rd=0 busy=1", bus.rom_rd, bus.busy);
    end
    tick();
    n_assert++;
    if (bus.rom_rd !== 1'b1 || bus.rom_addr !== 11'd0) begin
      n_fail++;
      $display("FAIL play_lat2: rd=%b addr=%0h expected rd=1 addr=0", bus.rom_rd, bus.rom_addr);
    end
    wait_idle(400, ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: busy still 1 expected 0"); end
    n_assert++;
    if (q_len.size() != 2 || q_len[0] != 12 || q_len[1] != 8) begin
      n_fail++;
      $display("FAIL basic_on_len: n=%0d len0=%0d len1=%0d expected 2,12,8",
               q_len.size(), q_len[0], q_len[1]);
    end
    n_assert++;
    if (q_pitch[0] != 60 || q_pitch[1] != 62) begin
      n_fail++;
      $display("FAIL basic_pitch: %0d,%0d expected 60,62", q_pitch[0], q_pitch[1]);
    end
    n_assert++;
    if (q_idx.size() != 2 || q_idx[0] != 0 || q_idx[1] != 1) begin
      n_fail++;
      $display("FAIL basic_index: n=%0d %0d,%0d expected 2,0,1", q_idx.size(), q_idx[0], q_idx[1]);
    end
    n_assert++;
    if (q_low[0] != 3 || q_low[1] != 7) begin
      n_fail++;
      $display("FAIL basic_low: %0d,%0d expected 3,7", q_low[0], q_low[1]);
    end
    n_assert++;
    if (done_cnt != 1 || bus.note_index !== 8'd0) begin
      n_fail++;
      $display("FAIL basic_done: done=%0d idx=%0d expected 1,0", done_cnt, bus.note_index);
    end
  endtask

  task automatic test_pause_resume();
    bit ok;
    int bad = 0;
    clear_mon();
    pulse_play();
    wait_on(50, ok);                // first on-cycle
    for (int i = 0; i < 4; i++) tick();
    bus.pause = 1'b1;               // during the 5th on-cycle
    tick();
    bus.pause = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.note_on !== 1'b0 || bus.busy !== 1'b1) bad++;
      tick();
    end
    n_assert++;
    if (!ok || bad != 0) begin
      n_fail++;
      $display("FAIL pause_hold: ok=%0d bad_cycles=%0d expected 1,0", ok, bad);
    end
    pulse_play();
    wait_idle(400, ok);
    n_assert++;
    if (!ok || q_len.size() != 3 || q_len[0] != 5 || q_len[1] != 7 || q_len[2] != 8) begin
      n_fail++;
      $display("FAIL pause_runs: n=%0d %0d,%0d,%0d expected 3,5,7,8",
               q_len.size(), q_len[0], q_len[1], q_len[2]);
    end
  endtask

  // pause during FETCH is held back until the first NOTE cycle.
  task automatic test_deferred_pause();
    bit ok;
    clear_mon();
    pulse_play();                   // now in FETCH
    bus.pause = 1'b1;
    tick();
    bus.pause = 1'b0;
    wait_on(50, ok);
    tick();
    n_assert++;
    if (!ok || bus.note_on !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL defer_paused: ok=%0d on=%b busy=%b expected 1,0,1", ok, bus.note_on, bus.busy);
    end
    for (int i = 0; i < 5; i++) tick();
    pulse_play();
    wait_idle(400, ok);
    n_assert++;
    if (!ok || q_len[0] != 1 || q_len[1] != 11) begin
      n_fail++;
      $display("FAIL defer_runs: %0d,%0d expected 1,11", q_len[0], q_len[1]);
    end
  endtask

  task automatic test_stop_wait_rom();
    int bad = 0;
    clear_mon();
    rom_lat = 3;
    pulse_play();
    tick();                         // WAIT_ROM, read strobe
    n_assert++;
    if (bus.rom_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_rd: rd=%b expected 1", bus.rom_rd);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    n_assert++;
    if (bus.busy !== 1'b0 || bus.note_on !== 1'b0 || bus.note_index !== 8'd0) begin
      n_fail++;
      $display("FAIL stop_idle: busy=%b on=%b idx=%0d expected 0,0,0",
               bus.busy, bus.note_on, bus.note_index);
    end
    for (int i = 0; i < 8; i++) begin
      if (bus.note_on !== 1'b0 || bus.busy !== 1'b0) bad++;
      tick();
    end
    n_assert++;
    if (bad != 0 || done_cnt != 0 || rd_cnt != 1) begin
      n_fail++;
      $display("FAIL stop_late_valid: bad=%0d done=%0d rd=%0d expected 0,0,1", bad, done_cnt, rd_cnt);
    end
    rom_lat = 1;
  endtask

  task automatic test_song_select();
    bit ok = 1'b0;
    clear_mon();
    exp_song = 3'd5; bus.song_select = 3'd5;
    pulse_play();
    bus.song_select = 3'd2;         // must not affect the running song
    for (int i = 0; i < 200; i++) begin
      if (bus.note_on === 1'b1 && bus.note_index === 8'd1) begin ok = 1'b1; break; end
      tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    exp_song = 3'd2;
    n_assert++;
    if (!ok || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_stop: reached=%0d busy=%b expected 1,0", ok, bus.busy);
    end
    pulse_play();
    wait_idle(300, ok);
    n_assert++;
    if (!ok || bad_song != 0 || rd_cnt != 4 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL sel_addr: bad_song=%0d rd=%0d done=%0d expected 0,4,1", bad_song, rd_cnt, done_cnt);
    end
    n_assert++;
    if (q_pitch.size() == 0 || q_pitch[q_pitch.size()-1] != 50) begin
      n_fail++;
      $display("FAIL sel_pitch: n=%0d expected last pitch 50", q_pitch.size());
    end
  endtask

  task automatic test_priority();
    bit ok;
    clear_mon();
    exp_song = 3'd0; bus.song_select = 3'd0;
    pulse_play();
    wait_on(50, ok);
    tick();
    tick();
    bus.stop = 1'b1; bus.play = 1'b1;
    tick();
    bus.stop = 1'b0; bus.play = 1'b0;
    n_assert++;
    if (!ok || bus.busy !== 1'b0 || bus.note_on !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_stop_play: busy=%b on=%b expected 0,0", bus.busy, bus.note_on);
    end
    bus.play = 1'b1; bus.pause = 1'b1;
    tick();
    bus.play = 1'b0; bus.pause = 1'b0;
    n_assert++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_play_pause: busy=%b expected 1", bus.busy);
    end
    wait_idle(400, ok);
    n_assert++;
    if (!ok || q_len.size() != 3 || q_len[0] != 3 || q_len[1] != 12 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL prio_runs: n=%0d %0d,%0d done=%0d expected 3,3,12,1",
               q_len.size(), q_len[0], q_len[1], done_cnt);
    end
  endtask

`ifndef SONG_SEQ_LOOP_EN
  // Song 7 has 256 real notes: the index wraps and that ends the song.
  task automatic test_index_wrap();
    bit ok;
    clear_mon();
    exp_song = 3'd7; bus.song_select = 3'd7;
    pulse_play();
    wait_idle(4000, ok);
    n_assert++;
    if (!ok || rd_cnt != 256 || q_len.size() != 256 || done_cnt != 1 || rd_idx0 != 1) begin
      n_fail++;
      $display("FAIL wrap: ok=%0d rd=%0d notes=%0d done=%0d idx0=%0d expected 1,256,256,1,1",
               ok, rd_cnt, q_len.size(), done_cnt, rd_idx0);
    end
    n_assert++;
    if (q_idx.size() != 256 || q_idx[255] != 255) begin
      n_fail++;
      $display("FAIL wrap_last_idx: n=%0d expected last index 255", q_idx.size());
    end
  endtask
`else
  // Song 1 = {40,1},end: 14 cycles per pass, so 100 cycles see at least 6 passes.
  task automatic test_loop();
    int bad = 0;
    clear_mon();
    exp_song = 3'd1; bus.song_select = 3'd1;
    pulse_play();
    for (int i = 0; i < 100; i++) begin
      if (bus.busy !== 1'b1) bad++;
      tick();
    end
    n_assert++;
    if (bad != 0 || done_cnt < 6 || rd_idx0 < 6 || bad_song != 0) begin
      n_fail++;
      $display("FAIL loop: bad_busy=%0d done=%0d idx0_reads=%0d bad_song=%0d expected 0,>=6,>=6,0",
               bad, done_cnt, rd_idx0, bad_song);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    n_assert++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_stop: busy=%b expected 0", bus.busy);
    end
  endtask
`endif

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) rom_mem[i] = '0;
    rom_mem[0]    = '{pitch: 7'd60, dur: 14'd3};
    rom_mem[1]    = '{pitch: 7'd62, dur: 14'd2};
    rom_mem[256]  = '{pitch: 7'd40, dur: 14'd1};
    rom_mem[512]  = '{pitch: 7'd50, dur: 14'd1};
    rom_mem[1280] = '{pitch: 7'd70, dur: 14'd2};
    rom_mem[1281] = '{pitch: 7'd71, dur: 14'd2};
    rom_mem[1282] = '{pitch: 7'd72, dur: 14'd2};
    for (int i = 0; i < 256; i++) rom_mem[1792 + i] = '{pitch: 7'(i), dur: 14'd1};
    bus.play = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    bus.song_select = 3'd0; bus.rom_valid = 1'b0; bus.rom_data = '0;
    exp_song = 3'd0; prev_on = 1'b0;
    clear_mon();
    test_reset();
    test_basic_song();
    test_pause_resume();
    test_deferred_pause();
    test_stop_wait_rom();
    test_song_select();
    test_priority();
`ifndef SONG_SEQ_LOOP_EN
    test_index_wrap();
`else
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
